// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
// Owns the snake body. Each segment position is held in its own register.
// An accepted step moves the body one segment per clock, starting at the
// tail and working toward the head. The new head is then loaded, and the
// body can grow by one. While the body moves, every old segment that
// survives the move is compared with the new head to detect self-collision.
//
// Ports
//   clk        in   system clock (rising edge)
//   reset      in   synchronous active-high reset
//   restart    in   synchronous re-initialise; same effect as reset
//   step       in   single-cycle move request, sampled only when idle
//   grow       in   grow request, sampled with an accepted step
//   head_next  in   new head {y,x}, sampled with an accepted step
//   busy       out  high while a move is in progress
//   done       out  one-cycle pulse when a move completes
//   self_hit   out  collision result of the last completed move
//   length     out  current segment count
//   rd_idx     in   renderer read index
//   rd_pos     out  seg[rd_idx], or 0 when rd_idx is out of storage range
//   rd_valid   out  rd_idx < length
module snake_body_ctrl #(
  parameter int MaxLen  = 16,
  parameter int CoordW  = 6,
  parameter int InitLen = 3,
  parameter int InitX   = 10,
  parameter int InitY   = 5,
  parameter int LenW    = $clog2(MaxLen + 1),
  parameter int PosW    = 2 * CoordW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            restart,
  input  logic            step,
  input  logic            grow,
  input  logic [PosW-1:0] head_next,
  output logic            busy,
  output logic            done,
  output logic            self_hit,
  output logic [LenW-1:0] length,
  input  logic [LenW-1:0] rd_idx,
  output logic [PosW-1:0] rd_pos,
  output logic            rd_valid
);

  localparam int IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam logic [LenW-1:0] MAX_LEN_L  = LenW'(MaxLen);
  localparam logic [LenW-1:0] INIT_LEN_L = LenW'(InitLen);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HEAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PosW-1:0]   seg_q [MaxLen];
  logic [PosW-1:0]   seg_d [MaxLen];
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   idx_q, idx_d;
  logic [PosW-1:0]   head_q, head_d;
  logic              grow_q, grow_d;
  logic              hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              self_hit_q, self_hit_d;

  // Position of segment i after reset: a horizontal line that extends
  // left from the initial head. Segments beyond the initial length are 0.
  function automatic logic [PosW-1:0] init_pos(input int i);
    if (i < InitLen) begin
      return {CoordW'(InitY), CoordW'(InitX - i)};
    end else begin
      return {PosW{1'b0}};
    end
  endfunction

  // Next-state logic for the move sequencer and the segment chain
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    len_d      = len_q;
    idx_d      = idx_q;
    head_d     = head_q;
    grow_d     = grow_q;
    hit_d      = hit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    self_hit_d = self_hit_q;
    case (state_q)
      IDLE: begin
        if (step) begin
          head_d = head_next;
          // A full snake cannot grow, so the move is handled as a plain move.
          grow_d = grow && (len_q < MAX_LEN_L);
          // When growing, the shift starts one slot past the tail, so the
          // old tail is kept and also takes part in the collision check.
          idx_d  = grow_d ? len_q : (len_q - {{(LenW-1){1'b0}}, 1'b1});
          hit_d  = 1'b0;
          busy_d = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        for (int i = 1; i < MaxLen; i++) begin
          if (idx_q == LenW'(i)) begin
            seg_d[i] = seg_q[i-1];
            if (seg_q[i-1] == head_q) begin
              hit_d = 1'b1;
            end else begin
              hit_d = hit_d;
            end
          end else begin
            seg_d[i] = seg_d[i];
          end
        end
        idx_d = idx_q - {{(LenW-1){1'b0}}, 1'b1};
        if (idx_q == {{(LenW-1){1'b0}}, 1'b1}) begin
          state_d = HEAD;
        end else begin
          state_d = SHIFT;
        end
      end
      HEAD: begin
        seg_d[0]   = head_q;
        len_d      = len_q + {{(LenW-1){1'b0}}, grow_q};
        self_hit_d = hit_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset and restart both return the body to its initial
  // shape, even in the middle of a move.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q    <= IDLE;
      len_q      <= INIT_LEN_L;
      idx_q      <= {LenW{1'b0}};
      head_q     <= {PosW{1'b0}};
      grow_q     <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      self_hit_q <= 1'b0;
      for (int i = 0; i < MaxLen; i++) begin
        seg_q[i] <= init_pos(i);
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      head_q     <= head_d;
      grow_q     <= grow_d;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      self_hit_q <= self_hit_d;
      for (int i = 0; i < MaxLen; i++) begin
        seg_q[i] <= seg_d[i];
      end
    end
  end

  // Renderer read port. It reads the registers directly, so the contents
  // are only meaningful while busy is low.
  always_comb begin
    rd_valid = (rd_idx < len_q);
    if (rd_idx < MAX_LEN_L) begin
      rd_pos = seg_q[rd_idx[IdxW-1:0]];
    end else begin
      rd_pos = {PosW{1'b0}};
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign self_hit = self_hit_q;
  assign length   = len_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed testbench for snake_body_ctrl (MaxLen=8, CoordW=6, InitLen=3,
// InitX=10, InitY=5). Expected values are written out by hand.
module tb_snake_body_ctrl;

  localparam int LenW = 4;
  localparam int PosW = 12;

  logic            clk;
  logic            reset;
  logic            restart;
  logic            step;
  logic            grow;
  logic [PosW-1:0] head_next;
  logic            busy;
  logic            done;
  logic            self_hit;
  logic [LenW-1:0] length;
  logic [LenW-1:0] rd_idx;
  logic [PosW-1:0] rd_pos;
  logic            rd_valid;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int snap = 0;

  snake_body_ctrl #(
    .MaxLen (8),
    .CoordW (6),
    .InitLen(3),
    .InitX  (10),
    .InitY  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .step     (step),
    .grow     (grow),
    .head_next(head_next),
    .busy     (busy),
    .done     (done),
    .self_hit (self_hit),
    .length   (length),
    .rd_idx   (rd_idx),
    .rd_pos   (rd_pos),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Count done pulses.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [PosW-1:0] p(input int x, input int y);
    return {6'(y), 6'(x)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input int i, input logic [PosW-1:0] exp);
    rd_idx = 4'(i);
    #1;
    chk($sformatf("seg%0d", i), 32'(rd_pos), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one step, then count busy cycles and check the done pulse.
  task automatic move(input logic [PosW-1:0] h, input logic g, input int exp_busy);
    int cnt;
    @(negedge clk);
    head_next = h;
    grow = g;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    grow = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(cnt), 32'(exp_busy));
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    restart = 1'b0;
    step = 1'b0;
    grow = 1'b0;
    head_next = '0;
    rd_idx = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. reset state
    chk("rst_len", 32'(length), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(self_hit), 32'd0);
    chk_seg(0, p(10, 5));
    chk_seg(1, p(9, 5));
    chk_seg(2, p(8, 5));
    for (int i = 3; i < 8; i++) chk_seg(i, 12'd0);
    rd_idx = 4'd3; #1;
    chk("rst_valid3", 32'(rd_valid), 32'd0);
    rd_idx = 4'd2; #1;
    chk("rst_valid2", 32'(rd_valid), 32'd1);
    rd_idx = 4'd9; #1;
    chk("rd_pos_oob", 32'(rd_pos), 32'd0);

    // 2. plain move
    move(p(11, 5), 1'b0, 3);
    chk_seg(0, p(11, 5));
    chk_seg(1, p(10, 5));
    chk_seg(2, p(9, 5));
    chk_seg(3, 12'd0);
    chk("m2_len", 32'(length), 32'd3);
    chk("m2_hit", 32'(self_hit), 32'd0);

    // 3. growing move
    move(p(12, 5), 1'b1, 4);
    chk("m3_len", 32'(length), 32'd4);
    chk_seg(0, p(12, 5));
    chk_seg(1, p(11, 5));
    chk_seg(2, p(10, 5));
    chk_seg(3, p(9, 5));
    rd_idx = 4'd3; #1;
    chk("m3_valid3", 32'(rd_valid), 32'd1);

    // 4. collision rules
    do_reset();
    move(p(8, 5), 1'b0, 3);
    chk("m4a_hit", 32'(self_hit), 32'd0);
    chk_seg(0, p(8, 5));
    chk_seg(2, p(9, 5));
    do_reset();
    move(p(8, 5), 1'b1, 4);
    chk("m4b_hit", 32'(self_hit), 32'd1);
    chk("m4b_len", 32'(length), 32'd4);
    do_reset();
    move(p(9, 5), 1'b0, 3);
    chk("m4c_hit", 32'(self_hit), 32'd1);
    // self_hit is replaced when the next move completes
    move(p(20, 5), 1'b0, 3);
    chk("m4d_hit", 32'(self_hit), 32'd0);

    // 5. grow to full length, then a growing move acts as a plain move
    do_reset();
    move(p(11, 5), 1'b1, 4);
    move(p(12, 5), 1'b1, 5);
    move(p(13, 5), 1'b1, 6);
    move(p(14, 5), 1'b1, 7);
    move(p(15, 5), 1'b1, 8);
    chk("m5_len8", 32'(length), 32'd8);
    chk_seg(7, p(8, 5));
    move(p(16, 5), 1'b1, 8);
    chk("m5_len_sat", 32'(length), 32'd8);
    for (int i = 0; i < 8; i++) chk_seg(i, p(16 - i, 5));
    chk("m5_hit", 32'(self_hit), 32'd0);

    // 6a. restart in the second SHIFT cycle aborts the move
    do_reset();
    move(p(9, 5), 1'b0, 3);
    chk("m6_prehit", 32'(self_hit), 32'd1);
    snap = done_cnt;
    @(negedge clk);
    head_next = p(30, 5);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("m6_busy_sh1", 32'(busy), 32'd1);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("m6_rs_busy", 32'(busy), 32'd0);
    chk("m6_rs_done", 32'(done), 32'd0);
    chk("m6_rs_hit", 32'(self_hit), 32'd0);
    chk("m6_rs_len", 32'(length), 32'd3);
    chk_seg(0, p(10, 5));
    chk_seg(1, p(9, 5));
    chk_seg(2, p(8, 5));
    repeat (5) @(negedge clk);
    chk("m6_no_done", 32'(done_cnt - snap), 32'd0);
    chk("m6_idle", 32'(busy), 32'd0);

    // 6b. a step pulsed while busy is ignored
    snap = done_cnt;
    @(negedge clk);
    head_next = p(11, 5);
    grow = 1'b0;
    step = 1'b1;
    @(negedge clk);
    head_next = p(20, 5);
    grow = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    grow = 1'b0;
    repeat (8) @(negedge clk);
    chk("m6b_done_cnt", 32'(done_cnt - snap), 32'd1);
    chk("m6b_len", 32'(length), 32'd3);
    chk("m6b_busy", 32'(busy), 32'd0);
    chk_seg(0, p(11, 5));
    chk_seg(1, p(10, 5));
    chk_seg(2, p(9, 5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
